// File: rtl/elevator_ctrl.sv
`default_nettype none
// elevator_ctrl: 4-floor car-motion controller (hall fetch handshake, car calls, travel, doors)
// Revision 1.0 - initial release
module elevator_ctrl #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       q_empty,
    input  logic [3:0] car_call,
    output logic       done,
    output logic [1:0] floor,
    output logic [1:0] target,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic [3:0] car_pend
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_MOVE  = 3'd3,
        S_DOOR  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] timer_q;
    logic [1:0]       floor_q;
    logic [1:0]       target_q;
    logic             done_q;
    logic             moving_q;
    logic             dir_up_q;
    logic             door_open_q;
    logic [3:0]       car_pend_q;

    logic [1:0]       w_pend_low;
    logic [1:0]       w_req_tgt;
    logic             w_req_ok;
    logic [1:0]       w_next_floor;
    logic [3:0]       w_floor_oh;
    logic [3:0]       w_pend_set;
    logic             w_disp_go;
    logic [1:0]       w_disp_tgt;

    always_comb begin
        w_pend_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (car_pend_q[i]) begin
                w_pend_low = 2'(i);
            end
        end
    end

    always_comb begin
        w_req_ok  = 1'b1;
        w_req_tgt = 2'd0;
        case (req)
            3'b001:         w_req_tgt = 2'd0;
            3'b010, 3'b110: w_req_tgt = 2'd1;
            3'b011, 3'b111: w_req_tgt = 2'd2;
            3'b100:         w_req_tgt = 2'd3;
            default:        w_req_ok  = 1'b0;
        endcase
    end

    assign w_next_floor = dir_up_q ? (floor_q + 2'd1) : (floor_q - 2'd1);
    assign w_floor_oh   = 4'b0001 << floor_q;
    // A call for the floor whose door is already open only extends the door.
    assign w_pend_set   = car_call & ~((state_q == S_DOOR) ? w_floor_oh : 4'b0000);

    // Pending car calls (from IDLE) and valid hall codes (from LATCH) share one dispatch path.
    assign w_disp_go  = ((state_q == S_IDLE)  && (car_pend_q != 4'b0000)) ||
                        ((state_q == S_LATCH) && w_req_ok);
    assign w_disp_tgt = (state_q == S_LATCH) ? w_req_tgt : w_pend_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            floor_q     <= 2'd0;
            target_q    <= 2'd0;
            done_q      <= 1'b0;
            moving_q    <= 1'b0;
            dir_up_q    <= 1'b1;
            door_open_q <= 1'b0;
            car_pend_q  <= 4'b0000;
        end else begin
            done_q     <= 1'b0;
            car_pend_q <= car_pend_q | w_pend_set;
            if (w_disp_go) begin
                target_q <= w_disp_tgt;
                timer_q  <= '0;
                if (w_disp_tgt == floor_q) begin
                    state_q              <= S_DOOR;
                    door_open_q          <= 1'b1;
                    car_pend_q[floor_q]  <= 1'b0;
                end else begin
                    state_q  <= S_MOVE;
                    moving_q <= 1'b1;
                    dir_up_q <= (w_disp_tgt > floor_q);
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!q_empty) begin
                            state_q <= S_FETCH;
                            done_q  <= 1'b1;
                        end
                    end
                    S_FETCH: state_q <= S_LATCH;
                    S_LATCH: state_q <= S_IDLE;
                    S_MOVE: begin
                        if (timer_q == TRAVEL_LAST) begin
                            timer_q <= '0;
                            floor_q <= w_next_floor;
                            if ((w_next_floor == target_q) || car_pend_q[w_next_floor]) begin
                                state_q                  <= S_DOOR;
                                moving_q                 <= 1'b0;
                                door_open_q              <= 1'b1;
                                car_pend_q[w_next_floor] <= 1'b0;
                            end
                        end else begin
                            timer_q <= timer_q + CNT_W'(1);
                        end
                    end
                    S_DOOR: begin
                        if (car_call[floor_q]) begin
                            timer_q <= '0;
                        end else if (timer_q == DOOR_LAST) begin
                            timer_q     <= '0;
                            door_open_q <= 1'b0;
                            if (floor_q != target_q) begin
                                state_q  <= S_MOVE;
                                moving_q <= 1'b1;
                                dir_up_q <= (target_q > floor_q);
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            timer_q <= timer_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign done      = done_q;
    assign floor     = floor_q;
    assign target    = target_q;
    assign moving    = moving_q;
    assign dir_up    = dir_up_q;
    assign door_open = door_open_q;
    assign car_pend  = car_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
`default_nettype none
// tb_elevator_ctrl: directed and randomized trips checked against a trip-level elevator model
// Revision 1.0 - initial release
module tb_elevator_ctrl;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       q_empty;
    logic [3:0] car_call;
    logic       done;
    logic [1:0] floor;
    logic [1:0] target;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic [3:0] car_pend;

    int checks = 0;
    int errors = 0;

    int         mv_cnt, dr_cnt, done_cnt;
    logic [3:0] pend_or;
    logic       prev_door;
    int         got_stops[$];
    int         exp_stops[$];
    int         exp_mv, exp_dr, exp_floor, exp_enc;
    int         hall_tgt[8] = '{-1, 0, 1, 2, 3, -1, 1, 2};

    elevator_ctrl #(
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DOOR),
        .CNT_W        (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .q_empty  (q_empty),
        .car_call (car_call),
        .done     (done),
        .floor    (floor),
        .target   (target),
        .moving   (moving),
        .dir_up   (dir_up),
        .door_open(door_open),
        .car_pend (car_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Trip model: serve lowest pending floor, stopping at any pending floor passed on the way.
    function automatic void model_trip(input int f0, input logic [3:0] pend0);
        int         f = f0;
        logic [3:0] p = pend0;
        int         t;
        exp_mv = 0;
        exp_dr = 0;
        exp_stops.delete();
        while (p != 4'b0000) begin
            t = 0;
            while (!p[t]) t++;
            if (t == f) begin
                exp_stops.push_back(f);
                p[f] = 1'b0;
                exp_dr += DOOR;
            end else begin
                while (f != t) begin
                    f += (t > f) ? 1 : -1;
                    exp_mv += TRAVEL;
                    if (f == t || p[f]) begin
                        exp_stops.push_back(f);
                        p[f] = 1'b0;
                        exp_dr += DOOR;
                    end
                end
            end
        end
        exp_floor = f;
    endfunction

    function automatic int enc(input int q[$]);
        int e = 0;
        foreach (q[i]) e = e * 5 + q[i] + 1;
        return e;
    endfunction

    task automatic set_exp(input int mv, input int dr, input int fl, input int se);
        exp_mv    = mv;
        exp_dr    = dr;
        exp_floor = fl;
        exp_enc   = se;
    endtask

    task automatic begin_meas();
        mv_cnt    = 0;
        dr_cnt    = 0;
        done_cnt  = 0;
        pend_or   = 4'b0000;
        prev_door = 1'b0;
        got_stops.delete();
    endtask

    task automatic window(input int ncyc, input int mv_at, input logic [3:0] mv_mask,
                          input int dr_at, input logic [3:0] dr_mask);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            car_call = 4'b0000;
            if (moving) begin
                mv_cnt++;
                if (mv_cnt == mv_at) car_call = mv_mask;
            end
            if (door_open) begin
                dr_cnt++;
                if (!prev_door) got_stops.push_back(int'(floor));
                if (dr_cnt == dr_at) car_call = dr_mask;
            end
            if (done) done_cnt++;
            pend_or   = pend_or | car_pend;
            prev_door = door_open;
        end
    endtask

    task automatic verify(input string tag);
        check({tag, "_moving_cycles"}, mv_cnt, exp_mv);
        check({tag, "_door_cycles"}, dr_cnt, exp_dr);
        check({tag, "_stop_seq"}, enc(got_stops), exp_enc);
        check({tag, "_floor"}, 32'(floor), exp_floor);
        check({tag, "_pend_clear"}, 32'(car_pend), 0);
        check({tag, "_settled"}, 32'({moving, door_open}), 0);
        check({tag, "_extra_done"}, done_cnt, 0);
    endtask

    task automatic hall(input logic [2:0] code, input int win, input int mv_at,
                        input logic [3:0] mv_mask, input int dr_at, input logic [3:0] dr_mask);
        q_empty = 1'b0;
        @(negedge clk);
        check("done_rise", 32'(done), 1);
        q_empty = 1'b1;
        req     = code;
        @(negedge clk);
        check("done_fall", 32'(done), 0);
        begin_meas();
        window(win, mv_at, mv_mask, dr_at, dr_mask);
        req = 3'b000;
    endtask

    initial begin
        logic [3:0] m;
        int         code;

        rst_n    = 1'b0;
        req      = 3'b000;
        q_empty  = 1'b1;
        car_call = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_floor", 32'(floor), 0);
        check("rst_target", 32'(target), 0);
        check("rst_done", 32'(done), 0);
        check("rst_moving", 32'(moving), 0);
        check("rst_dir_up", 32'(dir_up), 1);
        check("rst_door", 32'(door_open), 0);
        check("rst_pend", 32'(car_pend), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Hall 4D from floor 1: three floors up, one door cycle.
        set_exp(3 * TRAVEL, DOOR, 3, 4);
        hall(3'b100, 50, 0, 4'b0000, 0, 4'b0000);
        verify("hall_4d");
        check("hall_4d_target", 32'(target), 3);

        set_exp(TRAVEL, DOOR, 2, 3);
        hall(3'b011, 50, 0, 4'b0000, 0, 4'b0000);
        verify("hall_3u");

        set_exp(0, DOOR, 2, 3);
        hall(3'b011, 50, 0, 4'b0000, 0, 4'b0000);
        verify("same_floor");

        // Door extend: own-floor call in the third door cycle.
        set_exp(0, 3 + DOOR, 2, 3);
        hall(3'b011, 50, 0, 4'b0000, 3, 4'b0100);
        verify("door_extend");
        check("door_extend_no_pend", 32'(pend_or), 0);

        set_exp(0, 0, 2, 0);
        hall(3'b000, 20, 0, 4'b0000, 0, 4'b0000);
        verify("empty_code");

        // Car calls take priority over a non-empty hall queue.
        car_call = 4'b0110;
        @(negedge clk);
        car_call = 4'b0000;
        check("prio_pend", 32'(car_pend), 32'h6);
        q_empty = 1'b0;
        @(negedge clk);
        check("prio_target", 32'(target), 1);
        check("prio_no_done", 32'(done), 0);
        check("prio_moving", 32'(moving), 1);
        q_empty = 1'b1;
        begin_meas();
        mv_cnt = 1;
        window(100, 0, 4'b0000, 0, 4'b0000);
        set_exp(2 * TRAVEL, 2 * DOOR, 2, 13);
        verify("prio");

        set_exp(2 * TRAVEL, DOOR, 0, 1);
        hall(3'b001, 50, 0, 4'b0000, 0, 4'b0000);
        verify("hall_1u");

        // Intermediate stop: floor-2 car call during first floor of a 1->4 trip.
        set_exp(3 * TRAVEL, 2 * DOOR, 3, 14);
        hall(3'b100, 60, 3, 4'b0010, 0, 4'b0000);
        verify("intermediate");

        for (int n = 0; n < 10; n++) begin
            code = int'($urandom_range(0, 7));
            m    = (hall_tgt[code] < 0) ? 4'b0000 : 4'(1 << hall_tgt[code]);
            model_trip(int'(floor), m);
            exp_enc = enc(exp_stops);
            hall(3'(code), 50, 0, 4'b0000, 0, 4'b0000);
            verify("rand_hall");
        end

        for (int n = 0; n < 10; n++) begin
            m = 4'($urandom_range(1, 15));
            model_trip(int'(floor), m);
            exp_enc  = enc(exp_stops);
            car_call = m;
            begin_meas();
            window(100, 0, 4'b0000, 0, 4'b0000);
            verify("rand_calls");
        end

        // Asynchronous reset in the middle of a downward trip.
        model_trip(int'(floor), 4'b1000);
        exp_enc = enc(exp_stops);
        hall(3'b100, 50, 0, 4'b0000, 0, 4'b0000);
        verify("to_top");
        q_empty = 1'b0;
        @(negedge clk);
        q_empty = 1'b1;
        req     = 3'b001;
        @(negedge clk);
        car_call = 4'b0001;
        @(negedge clk);
        car_call = 4'b0000;
        repeat (12) @(negedge clk);
        check("pre_rst_moving", 32'(moving), 1);
        check("pre_rst_floor", 32'(floor), 2);
        check("pre_rst_pend", 32'(car_pend), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_floor", 32'(floor), 0);
        check("async_rst_target", 32'(target), 0);
        check("async_rst_moving", 32'(moving), 0);
        check("async_rst_dir_up", 32'(dir_up), 1);
        check("async_rst_door", 32'(door_open), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_pend", 32'(car_pend), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 3'b000;
        repeat (3) @(negedge clk);
        check("post_rst_floor", 32'(floor), 0);
        check("post_rst_idle", 32'({moving, door_open, done}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
